board_mem_ctrl: RTL and testbench

- Owns the 1024-cell board tile memory that sits directly downstream of the board-reset sweeper.
- While the sweeper asserts hold, writes its initial_data stream into memory and counts pellets.
- Otherwise serves gameplay: collision/tile reads, pellet-eat read-modify-write, and a VGA read port.
- Drives pellet_count and level_clear to the game FSM, and score/power pulses to the score logic.

---
 rtl/board_pkg.sv | 21 ++
 rtl/board_ram.sv | 39 +++
 rtl/board_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_board_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared widths, tile codes and eat-FSM state encoding for the board tile memory.
package board_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [DATA_W-1:0] {
        EMPTY  = 4'd0,
        WALL   = 4'd1,
        PELLET = 4'd2,
        POWER  = 4'd3
    } tile_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CHK  = 2'd2
    } eat_state_t;

endpackage

// File: rtl/board_ram.sv
// Board tile RAM: one write port, two synchronous read ports, read-first.
module board_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_data,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array itself is never reset; the sweeper rewrites every cell, and a
    // reset on the array would prevent it from mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking reads sample the array before this edge's write lands,
    // which is exactly the read-first behaviour the ports promise.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            a_data <= mem[a_addr];
            b_data <= mem[b_addr];
        end
    end

endmodule

// File: rtl/board_mem_ctrl.sv
// Board tile memory controller: sweeper init load, pellet-eat read-modify-write,
// game/VGA read ports, pellet counter and level-clear flag.
module board_mem_ctrl
    import board_pkg::*;
#(
    parameter int ADDR_W = board_pkg::ADDR_W,
    parameter int DATA_W = board_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [ADDR_W-1:0] overwrite_addr,
    input  logic [DATA_W-1:0] initial_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    input  logic              eat_req,
    input  logic [ADDR_W-1:0] eat_addr,
    output logic              eat_ack,
    output logic              score_pulse,
    output logic              power_pulse,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic [ADDR_W-1:0] pellet_count,
    output logic              level_clear
);

    eat_state_t        state, state_next;
    logic [ADDR_W-1:0] eat_addr_q;
    logic              hold_d;
    logic              loaded;

    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] a_addr;

    logic              accept;
    logic              chk_live;
    logic              eat_hit;
    logic              init_edible;

    assign accept      = (state == IDLE) && eat_req && !hold;
    assign chk_live    = (state == CHK) && !hold;
    assign eat_hit     = chk_live && ((rd_data == PELLET) || (rd_data == POWER));
    assign init_edible = (initial_data == PELLET) || (initial_data == POWER);

    board_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .a_addr  (a_addr),
        .a_data  (rd_data),
        .b_addr  (vga_addr),
        .b_data  (vga_data)
    );

    // The sweeper always wins the write port; an eat write is dropped under reset.
    always_comb begin
        if (hold) begin
            we      = 1'b1;
            wr_addr = overwrite_addr;
            wr_data = initial_data;
        end else begin
            we      = eat_hit && !reset;
            wr_addr = eat_addr_q;
            wr_data = EMPTY;
        end
    end

    assign a_addr = busy ? eat_addr_q : rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            eat_addr_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                eat_addr_q <= eat_addr;
            end
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RD;
            RD:      state_next = hold ? IDLE : CHK;
            CHK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        eat_ack     = chk_live;
        score_pulse = chk_live && (rd_data == PELLET);
        power_pulse = chk_live && (rd_data == POWER);
    end

    // A hold rising edge restarts the count with this cycle's write already included.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_d       <= 1'b0;
            loaded       <= 1'b0;
            pellet_count <= '0;
            level_clear  <= 1'b0;
        end else begin
            hold_d <= hold;
            if (hold && !hold_d) begin
                loaded <= 1'b0;
            end else if (!hold && hold_d) begin
                loaded <= 1'b1;
            end

            if (hold) begin
                pellet_count <= (hold_d ? pellet_count : '0) + ADDR_W'(init_edible);
            end else if (eat_hit && (pellet_count != '0)) begin
                pellet_count <= pellet_count - 1'b1;
            end

            level_clear <= loaded && !hold && (pellet_count == '0);
        end
    end

endmodule

// File: tb/tb_board_mem_ctrl.sv
// Self-checking bench for board_mem_ctrl: table-driven eats, hand-written corner
// sequences, and randomized traffic against a cell-array reference model.
module tb_board_mem_ctrl;
    import board_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              hold;
    logic [ADDR_W-1:0] overwrite_addr;
    logic [DATA_W-1:0] initial_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              eat_req;
    logic [ADDR_W-1:0] eat_addr;
    logic              eat_ack;
    logic              score_pulse;
    logic              power_pulse;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic [ADDR_W-1:0] pellet_count;
    logic              level_clear;

    always #5 clk = ~clk;

    board_mem_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .hold           (hold),
        .overwrite_addr (overwrite_addr),
        .initial_data   (initial_data),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .eat_req        (eat_req),
        .eat_addr       (eat_addr),
        .eat_ack        (eat_ack),
        .score_pulse    (score_pulse),
        .power_pulse    (power_pulse),
        .vga_addr       (vga_addr),
        .vga_data       (vga_data),
        .pellet_count   (pellet_count),
        .level_clear    (level_clear)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what each cell should hold and how many pellets remain.
    int model_mem [DEPTH];
    int model_count;

    typedef struct {
        int addr;
        int exp_tile;
        int exp_count;
    } eat_vec_t;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit edible(input int t);
        return (t == 2) || (t == 3);
    endfunction

    // Returns the tile the eat should see and applies its effect to the model.
    task automatic model_eat(input int addr, output int tile, output int count_after);
        tile = model_mem[addr];
        if (edible(tile)) begin
            model_mem[addr] = 0;
            if (model_count > 0) model_count--;
        end
        count_after = model_count;
    endtask

    task automatic sweep(input bit rnd, input bit req_during);
        model_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int t;
            if (rnd) t = int'($urandom_range(0, 15));
            else     t = (i < 10) ? 2 : ((i == 10) ? 3 : 1);
            hold           = 1'b1;
            overwrite_addr = ADDR_W'(i);
            initial_data   = DATA_W'(t);
            eat_req        = req_during;
            eat_addr       = ADDR_W'($urandom_range(0, DEPTH - 1));
            model_mem[i]   = t;
            if (edible(t)) model_count++;
            tick();
            if (req_during) begin
                check("ack_during_hold", int'(eat_ack), 0);
                check("busy_during_hold", int'(busy), 0);
            end
        end
        hold    = 1'b0;
        eat_req = 1'b0;
        tick();
        check("count_after_sweep", int'(pellet_count), model_count);
    endtask

    task automatic read_check(input int a, input int b);
        rd_addr  = ADDR_W'(a);
        vga_addr = ADDR_W'(b);
        tick();
        check("rd_data", int'(rd_data), model_mem[a]);
        check("vga_data", int'(vga_data), model_mem[b]);
    endtask

    task automatic do_eat(input int addr, input int exp_tile, input int exp_count);
        eat_req  = 1'b1;
        eat_addr = ADDR_W'(addr);
        tick();
        eat_req  = 1'b0;
        eat_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        check("busy_rd", int'(busy), 1);
        check("ack_rd", int'(eat_ack), 0);
        tick();
        check("busy_chk", int'(busy), 1);
        check("ack_chk", int'(eat_ack), 1);
        check("tile_chk", int'(rd_data), exp_tile);
        check("score_chk", int'(score_pulse), int'(exp_tile == 2));
        check("power_chk", int'(power_pulse), int'(exp_tile == 3));
        tick();
        check("busy_done", int'(busy), 0);
        check("ack_done", int'(eat_ack), 0);
        check("pulse_done", int'(score_pulse | power_pulse), 0);
        check("count_done", int'(pellet_count), exp_count);
    endtask

    initial begin
        eat_vec_t vecs [3];
        int       tile;
        int       cnt;
        int       rest [9];

        vecs[0] = '{addr: 3,  exp_tile: 2, exp_count: 10};
        vecs[1] = '{addr: 10, exp_tile: 3, exp_count: 9};
        vecs[2] = '{addr: 20, exp_tile: 1, exp_count: 9};
        rest    = '{0, 1, 2, 4, 5, 6, 7, 8, 9};

        reset = 1'b1; hold = 1'b0; overwrite_addr = '0; initial_data = '0;
        rd_addr = '0; eat_req = 1'b0; eat_addr = '0; vga_addr = '0;
        tick();
        tick();
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_vga_data", int'(vga_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(eat_ack), 0);
        check("rst_count", int'(pellet_count), 0);
        check("rst_level_clear", int'(level_clear), 0);
        reset = 1'b0;

        sweep(1'b0, 1'b0);
        check("count_fixed", int'(pellet_count), 11);
        read_check(5, 5);
        check("vga_addr5", int'(vga_data), 2);
        check("level_clear_loaded", int'(level_clear), 0);

        foreach (vecs[i]) begin
            model_eat(vecs[i].addr, tile, cnt);
            do_eat(vecs[i].addr, vecs[i].exp_tile, vecs[i].exp_count);
            read_check(vecs[i].addr, vecs[i].addr);
            check("cell_after_eat", int'(rd_data), (vecs[i].exp_tile == 1) ? 1 : 0);
        end

        foreach (rest[i]) begin
            model_eat(rest[i], tile, cnt);
            do_eat(rest[i], tile, cnt);
        end
        check("count_all_eaten", int'(pellet_count), 0);
        tick();
        check("level_clear_set", int'(level_clear), 1);

        model_eat(3, tile, cnt);
        do_eat(3, 0, 0);
        check("level_clear_hold", int'(level_clear), 1);

        // hold arrives while the FSM is in RD: the eat is abandoned
        eat_req  = 1'b1;
        eat_addr = ADDR_W'(5);
        tick();
        eat_req = 1'b0;
        check("busy_before_hold", int'(busy), 1);
        sweep(1'b0, 1'b1);
        check("recount", int'(pellet_count), 11);
        read_check(5, 5);
        check("cell5_untouched", int'(rd_data), 2);

        // reset during CHK: everything drops and the pellet survives
        eat_req  = 1'b1;
        eat_addr = ADDR_W'(0);
        tick();
        eat_req = 1'b0;
        tick();
        check("ack_before_reset", int'(eat_ack), 1);
        reset = 1'b1;
        tick();
        check("rr_busy", int'(busy), 0);
        check("rr_ack", int'(eat_ack), 0);
        check("rr_score", int'(score_pulse), 0);
        check("rr_power", int'(power_pulse), 0);
        check("rr_rd_data", int'(rd_data), 0);
        check("rr_vga_data", int'(vga_data), 0);
        check("rr_count", int'(pellet_count), 0);
        check("rr_level_clear", int'(level_clear), 0);
        reset = 1'b0;
        model_count = 0;
        read_check(0, 0);
        check("cell0_after_reset", int'(vga_data), 2);

        // randomized board, eats and reads against the model
        sweep(1'b1, 1'b0);
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                int a;
                a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1))
                                                : int'($urandom_range(0, 63));
                model_eat(a, tile, cnt);
                do_eat(a, tile, cnt);
            end else begin
                read_check(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
                check("level_clear_rand", int'(level_clear), int'(model_count == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
